// File: rtl/array_24_pkg.sv
// Shared constants, request bundle and FSM state encoding for the array_24 front-end controller.
// The zero-fill feature is selected by defining ARRAY_24_CTRL_INIT_EN.
package array_24_pkg;

  localparam int ARRAY_24_DEPTH  = 256;
  localparam int ARRAY_24_ADDR_W = 8;
  localparam int ARRAY_24_DATA_W = 96;
  localparam int ARRAY_24_MASK_W = 4;
  localparam int ARRAY_24_GRAN   = 24;

  typedef struct packed {
    logic [ARRAY_24_ADDR_W-1:0] addr;
    logic                       wmode;
    logic [ARRAY_24_MASK_W-1:0] wmask;
    logic [ARRAY_24_DATA_W-1:0] wdata;
  } array_24_req_t;

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } array_24_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: a lone requester always wins, on contention the
// requester named by prio wins, and prio then points at the loser.
module rr_arb2 (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic [1:0] valid,
  output logic [1:0] grant
);

  logic prio;

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    grant = 2'b00;
    if (enable) begin
      unique case (valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = prio ? 2'b10 : 2'b01;
        default: grant = 2'b00;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      prio <= 1'b0;
    end else if (|grant) begin
      prio <= grant[0];
    end
  end

endmodule

// File: rtl/array_24_ctrl.sv
// Front-end controller sharing the 256x96 masked 1RW array between two requesters.
// Define ARRAY_24_CTRL_INIT_EN to zero-fill the array after every reset before accepting traffic.
module array_24_ctrl
  import array_24_pkg::*;
(
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       req0_valid,
  output logic                       req0_ready,
  input  logic [ARRAY_24_ADDR_W-1:0] req0_addr,
  input  logic                       req0_wmode,
  input  logic [ARRAY_24_MASK_W-1:0] req0_wmask,
  input  logic [ARRAY_24_DATA_W-1:0] req0_wdata,
  input  logic                       req1_valid,
  output logic                       req1_ready,
  input  logic [ARRAY_24_ADDR_W-1:0] req1_addr,
  input  logic                       req1_wmode,
  input  logic [ARRAY_24_MASK_W-1:0] req1_wmask,
  input  logic [ARRAY_24_DATA_W-1:0] req1_wdata,
  output logic                       resp0_valid,
  output logic [ARRAY_24_DATA_W-1:0] resp0_data,
  output logic                       resp1_valid,
  output logic [ARRAY_24_DATA_W-1:0] resp1_data,
  output logic                       sram_en,
  output logic                       sram_wmode,
  output logic [ARRAY_24_ADDR_W-1:0] sram_addr,
  output logic [ARRAY_24_MASK_W-1:0] sram_wmask,
  output logic [ARRAY_24_DATA_W-1:0] sram_wdata,
  input  logic [ARRAY_24_DATA_W-1:0] sram_rdata,
  output logic                       init_done
);

  array_24_req_t req0;
  array_24_req_t req1;
  array_24_req_t sel;
  logic [1:0]    valid;
  logic [1:0]    grant;
  logic          accept_en;
  logic          rd_pend;
  logic          rd_src;

  assign req0  = '{addr: req0_addr, wmode: req0_wmode, wmask: req0_wmask, wdata: req0_wdata};
  assign req1  = '{addr: req1_addr, wmode: req1_wmode, wmask: req1_wmask, wdata: req1_wdata};
  assign valid = {req1_valid, req0_valid};

  // init_done tracks the RUN state; the reset term keeps the port quiet while reset is sampled.
  assign accept_en = init_done & ~reset;

  rr_arb2 u_arb (
    .clock  (clock),
    .reset  (reset),
    .enable (accept_en),
    .valid  (valid),
    .grant  (grant)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign sel        = grant[1] ? req1 : req0;

`ifdef ARRAY_24_CTRL_INIT_EN
  localparam logic [0:0] STATE_INIT = INIT;
  localparam logic [0:0] STATE_RUN  = RUN;

  logic [0:0]                 state;
  logic [ARRAY_24_ADDR_W-1:0] ptr;
  logic                       in_init;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= STATE_INIT;
      ptr       <= '0;
      init_done <= 1'b0;
    end else if (state == STATE_INIT) begin
      ptr <= ptr + 1'b1;
      if (ptr == ARRAY_24_ADDR_W'(ARRAY_24_DEPTH - 1)) begin
        state     <= STATE_RUN;
        init_done <= 1'b1;
      end
    end
  end

  assign in_init = (state == STATE_INIT) & ~reset;
`else
  always_ff @(posedge clock) begin
    if (reset) begin
      init_done <= 1'b0;
    end else begin
      init_done <= 1'b1;
    end
  end
`endif

  always_comb begin
    sram_en    = 1'b0;
    sram_wmode = 1'b0;
    sram_addr  = '0;
    sram_wmask = '0;
    sram_wdata = '0;
    if (|grant) begin
      sram_en    = 1'b1;
      sram_wmode = sel.wmode;
      sram_addr  = sel.addr;
      sram_wmask = sel.wmask;
      sram_wdata = sel.wdata;
    end
`ifdef ARRAY_24_CTRL_INIT_EN
    else if (in_init) begin
      sram_en    = 1'b1;
      sram_wmode = 1'b1;
      sram_addr  = ptr;
      sram_wmask = '1;
    end
`endif
  end

  // The macro returns read data one cycle after the enable; remember who asked.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_pend <= 1'b0;
      rd_src  <= 1'b0;
    end else begin
      rd_pend <= (|grant) & ~sel.wmode;
      if (|grant) begin
        rd_src <= grant[1];
      end
    end
  end

  assign resp0_valid = rd_pend & ~rd_src;
  assign resp1_valid = rd_pend & rd_src;
  assign resp0_data  = resp0_valid ? sram_rdata : '0;
  assign resp1_data  = resp1_valid ? sram_rdata : '0;

endmodule

// File: doc/array_24_ctrl.md
# array_24_ctrl

Front-end controller for the 256 x 96-bit, 24-bit-granular masked single-port (1RW) array macro. It shares the macro's single RW port between two requesters using round-robin arbitration with valid/ready handshakes. It returns read data to the originating requester with fixed latency. Optionally, it zero-fills the whole array after reset before accepting traffic. It sits between the cache/tag logic (requesters) and the array macro instance.

## Interface
- DEPTH, 256, array entries
- ADDR_W, 8, address width (log2 DEPTH)
- DATA_W, 96, data width
- MASK_W, 4, write-mask lanes (24 bits each)
- clock  in  1  sole clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- req0_valid / req1_valid  in  1  request present
- req0_ready / req1_ready  out  1  request accepted this cycle when valid & ready
- reqN_addr  in  ADDR_W  entry address
- reqN_wmode  in  1  1 = write, 0 = read
- reqN_wmask  in  MASK_W  lane enables (writes only)
- reqN_wdata  in  DATA_W  write data
- resp0_valid / resp1_valid  out  1  read data valid (no backpressure)
- respN_data  out  DATA_W  read data
- sram_en  out  1  macro enable
- sram_wmode  out  1  macro write mode
- sram_addr  out  ADDR_W  macro address
- sram_wmask  out  MASK_W  macro write mask
- sram_wdata  out  DATA_W  macro write data
- sram_rdata  in  DATA_W  macro read data, valid the cycle after a read enable
- init_done  out  1  array ready for traffic

## Operation
- FSM states: INIT, RUN.
- Reset enters INIT when ARRAY_24_CTRL_INIT_EN is defined; otherwise it enters RUN.
- INIT:
  - 8-bit counter `ptr` starts at 0.
  - Each cycle drives sram_en=1, wmode=1, wmask=4'hF, wdata=0, addr=ptr, then increments ptr.
  - After the write at ptr=255, the FSM moves to RUN.
  - Both reqN_ready are held 0 for the whole of INIT.
- RUN:
  - The arbiter grants one valid requester per cycle.
  - If exactly one requester is valid, it is granted.
  - If both are valid, the requester indicated by the priority bit `prio` is granted.
  - After any grant, prio points to the non-granted requester.
  - prio resets to 0 (requester 0 first).
- Grant drives the macro port combinationally from the granted request: sram_en=1, plus its addr, wmode, wmask and wdata.
- With no grant: sram_en=0 and all other sram_* outputs are 0.
- ready is asserted only to the granted requester.
- ready never depends on respN state; ready depends on valid (grant is combinational).
- Reads:
  - A registered `rd_pend` (1 bit) and `rd_src` (1 bit) are captured on a read grant.
  - respN_valid = rd_pend & (rd_src==N).
  - respN_data = sram_rdata, passed through combinationally. respN_data is 0 when respN_valid=0.
- Writes produce no response. A masked-off lane leaves stored data unchanged.
- Back-to-back operations to the same address are ordered by grant order. A read granted the cycle after a write to the same address returns the written data.
- init_done = (state==RUN), registered.

## Timing
- Reset values: reqN_ready=0, respN_valid=0, respN_data=0, sram_en=0, sram_* = 0, init_done=0, prio=0, ptr=0, rd_pend=0.
- Throughput is 1 request per cycle total across both requesters.
- Read latency: accepted at cycle T, respN_valid at T+1.
- INIT duration: the first clock edge with reset low starts write 0. Write 255 occurs at cycle 255 after reset release. init_done=1 from cycle 256.
- Without the macro, init_done=1 from the first cycle after reset release, and requests are accepted in that same cycle.
- Reset asserted mid-INIT: ptr returns to 0 and INIT restarts completely.
- Reset asserted mid-RUN: any pending read response is dropped (respN_valid=0 next cycle) and prio returns to 0.
- Requester dropping valid without a grant: legal, no state change.

## Configuration
- ARRAY_24_CTRL_INIT_EN defined:
  - INIT state and the 8-bit ptr counter are compiled in.
  - The array is zero-filled after every reset.
- Not defined:
  - No INIT state and no counter.
  - Array contents after reset are whatever the macro holds.
  - FSM is RUN only.

## Structure
- Package array_24_pkg:
  - Constants ARRAY_24_DEPTH=256, ARRAY_24_ADDR_W=8, ARRAY_24_DATA_W=96, ARRAY_24_MASK_W=4, ARRAY_24_GRAN=24.
  - Typedef for the request bundle (addr, wmode, wmask, wdata).
  - Enum for FSM state {INIT, RUN}.
- Sub-module rr_arb2: 2-way round-robin arbiter holding prio, with inputs valid[1:0] and outputs grant[1:0] (one-hot or zero).
- Top module: FSM, init counter, port mux, read-return tracking.

## Test plan
- Init fill (macro defined): release reset. Expect 256 consecutive writes addr 0..255, wmask=F, wdata=0. init_done rises at cycle 256. Reading addr 0x7F afterwards returns 96'h0.
- Reset mid-INIT: assert reset at ptr=100, release it. Expect the next write at addr 0. init_done at cycle 256 after the second release.
- Contention: both requesters hold reads (req0 addr 1, req1 addr 2) for 4 cycles. Expect grants 0,1,0,1. resp0_valid/resp1_valid alternate one cycle after each grant with the correct data.
- Masked write: write addr 5 with data all-ones, mask F. Then write addr 5 with data 0, mask 4'b0101. A read of addr 5 returns 96'hFFFFFF_000000_FFFFFF_000000.
- Write→read same address back-to-back: req0 writes 0xA5.. to addr 9, then req1 reads addr 9 the next cycle. Expect resp1 with 0xA5.. at grant+1.
- Reset mid-RUN: a read is granted in cycle T and reset is asserted in cycle T. Expect resp valid=0 at T+1, prio=0, and sram_en=0.
